// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and SHA-256 round/schedule functions
// for the iterative compression engine.
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// On-the-fly SHA-256 message schedule: 16-word sliding window,
// W[t] is always the oldest word in the window.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [511:0] block_i,
    output logic [31:0]  w_o
);

    logic [15:0][31:0] win_q, win_d;
    logic [31:0]       new_w;

    assign new_w = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

    always_comb begin
        win_d = win_q;
        if (load_i) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = block_i[511 - 32*i -: 32];
            end
        end else if (shift_i) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[15] = new_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign w_o = win_q[0];

endmodule

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression core, one round per clock.
// SHA256_FEEDFWD_EN: outputs carry the full digest (h_in + final vars).
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [511:0]      block_in,
    input  logic [255:0]      h_in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] a_out,
    output logic [WORD_W-1:0] b_out,
    output logic [WORD_W-1:0] c_out,
    output logic [WORD_W-1:0] d_out,
    output logic [WORD_W-1:0] e_out,
    output logic [WORD_W-1:0] f_out,
    output logic [WORD_W-1:0] g_out,
    output logic [WORD_W-1:0] h_out
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_e            state_q, state_d;
    logic [5:0]        t_q, t_d;
    // index 7 = a ... index 0 = h, same layout as h_in
    logic [7:0][31:0]  v_q, v_d;
    logic [255:0]      out_q, out_d;
    logic [7:0][31:0]  rnd;
    logic [31:0]       w_t, t1, t2;
    logic              sched_load, sched_shift;
`ifdef SHA256_FEEDFWD_EN
    logic [255:0]      hin_q, hin_d;
`endif

    sha256_msg_sched u_sched (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sched_load),
        .shift_i (sched_shift),
        .block_i (block_in),
        .w_o     (w_t)
    );

    always_comb begin
        t1 = v_q[0] + bsig1(v_q[3]) + ch(v_q[3], v_q[2], v_q[1])
           + K[t_q] + w_t;
        t2 = bsig0(v_q[7]) + maj(v_q[7], v_q[6], v_q[5]);
        rnd = {t1 + t2, v_q[7], v_q[6], v_q[5],
               v_q[4] + t1, v_q[3], v_q[2], v_q[1]};
    end

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        v_d         = v_q;
        out_d       = out_q;
        sched_load  = 1'b0;
        sched_shift = 1'b0;
`ifdef SHA256_FEEDFWD_EN
        hin_d       = hin_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    t_d        = '0;
                    v_d        = h_in;
                    sched_load = 1'b1;
`ifdef SHA256_FEEDFWD_EN
                    hin_d      = h_in;
`endif
                end
            end
            ST_RUN: begin
                v_d         = rnd;
                sched_shift = 1'b1;
                t_d         = t_q + 6'd1;
                if (t_q == LAST_T) begin
                    state_d = ST_DONE;
                    t_d     = '0;
`ifdef SHA256_FEEDFWD_EN
                    out_d   = add_words(hin_q, rnd);
`else
                    out_d   = rnd;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            v_q     <= '0;
            out_q   <= '0;
`ifdef SHA256_FEEDFWD_EN
            hin_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            v_q     <= v_d;
            out_q   <= out_d;
`ifdef SHA256_FEEDFWD_EN
            hin_q   <= hin_d;
`endif
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out} = out_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known-answer blocks, latency,
// ignored starts, mid-run reset, back-to-back operation, input isolation.
module tb_sha256_round_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] h_in;
    logic         busy, done;
    logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_round_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .block_in (block_in),
        .h_in     (h_in),
        .busy     (busy),
        .done     (done),
        .a_out    (a_out),
        .b_out    (b_out),
        .c_out    (c_out),
        .d_out    (d_out),
        .e_out    (e_out),
        .f_out    (f_out),
        .g_out    (g_out),
        .h_out    (h_out)
    );

    localparam logic [255:0] TB_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_RAW = {
        32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
        32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894
    };
    localparam logic [255:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] TWO_DIG = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
    };
`ifdef SHA256_FEEDFWD_EN
    localparam logic [255:0] ABC_EXP = ABC_DIG;
`else
    localparam logic [255:0] ABC_EXP = ABC_RAW;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] outs();
        return {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out};
    endfunction

    // downstream H-stage accumulate, wordwise mod 2^32
    function automatic logic [255:0] hadd(input logic [255:0] x, y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

    task automatic chk_vec(input string tag, input logic [255:0] obs,
                           input logic [255:0] exp);
        for (int i = 7; i >= 0; i--) chk(tag, obs[i*32 +: 32], exp[i*32 +: 32]);
    endtask

    // lat counts negedges after the start-sampling edge until done is seen
    task automatic run_blk(input logic [511:0] blk, input logic [255:0] hin,
                           input int pa, input int pb, input bit chg,
                           output int lat, output bit b1);
        @(negedge clk);
        block_in = blk;
        h_in     = hin;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        b1    = busy;
        if (chg) begin
            block_in = ~blk;
            h_in     = ~hin;
        end
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            start = (lat == pa) || (lat == pb);
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int lat, n, nb;
        bit b1;
        logic [255:0] o1, h2, dig;

        rst_n    = 1'b0;
        start    = 1'b0;
        block_in = '0;
        h_in     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_a", a_out, 32'd0);
        chk("rst_h", h_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: "abc"
        run_blk(ABC_BLK, TB_IV, 0, 0, 1'b0, lat, b1);
        chk("abc_lat", lat, 32'd65);
        chk("abc_busy", {31'd0, b1}, 32'd1);
        chk("abc_idle", {31'd0, busy | done}, 32'd0);
        chk_vec("abc", outs(), ABC_EXP);
        repeat (5) @(negedge clk);
        chk("abc_hold", a_out, ABC_EXP[255:224]);

        // 2: two-block message chained through H-stage model
        run_blk(TWO_B1, TB_IV, 0, 0, 1'b0, lat, b1);
        o1 = outs();
`ifdef SHA256_FEEDFWD_EN
        h2 = o1;
`else
        h2 = hadd(TB_IV, o1);
`endif
        run_blk(TWO_B2, h2, 0, 0, 1'b0, lat, b1);
`ifdef SHA256_FEEDFWD_EN
        dig = outs();
`else
        dig = hadd(h2, outs());
`endif
        chk_vec("two_blk", dig, TWO_DIG);

        // 3: starts during RUN and DONE are ignored
        run_blk(ABC_BLK, TB_IV, 10, 65, 1'b0, lat, b1);
        chk("ign_lat", lat, 32'd65);
        n  = 0;
        nb = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) n++;
            if (busy) nb++;
        end
        chk("ign_done", n, 32'd0);
        chk("ign_busy", nb, 32'd0);
        chk("ign_a", a_out, ABC_EXP[255:224]);

        // 6: inputs changed during RUN
        run_blk(TWO_B1, TB_IV, 0, 0, 1'b0, lat, b1);
        run_blk(ABC_BLK, TB_IV, 0, 0, 1'b1, lat, b1);
        chk_vec("chg", outs(), ABC_EXP);

        // 4: reset mid-run
        @(negedge clk);
        block_in = ABC_BLK;
        h_in     = TB_IV;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_a", a_out, 32'd0);
        chk("mrst_e", e_out, 32'd0);
        n = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("mrst_nodone", n, 32'd0);
        run_blk(ABC_BLK, TB_IV, 0, 0, 1'b0, lat, b1);
        chk("mrst_lat", lat, 32'd65);
        chk("mrst_e2", e_out, ABC_EXP[127:96]);

        // 5: start held high -> done every 66 cycles
        @(negedge clk);
        block_in = ABC_BLK;
        h_in     = TB_IV;
        start    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        chk("b2b_first", {31'd0, done}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        start = 1'b0;
        chk("b2b_period", n, 32'd66);
        chk("b2b_a", a_out, ABC_EXP[255:224]);
        repeat (3) @(negedge clk);
        chk("b2b_stop", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
